// File: rtl/gsim_pkg.sv
// Shared constants, types and the FSM state encoding for the Gauss-Seidel
// result path. Imported by gsim_result_buffer and gsim_round_sat.
package gsim_pkg;

  localparam int GSIM_N    = 16;  // solution words per burst
  localparam int GSIM_DW   = 32;  // word width, 16.16 signed fixed point
  localparam int GSIM_FRAC = 16;  // fractional bits of a solution word

  typedef logic signed [GSIM_DW-1:0] gsim_word_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } gsim_rb_state_t;

endpackage : gsim_pkg

// File: rtl/gsim_round_sat.sv
// Round-to-nearest-integer for a signed fixed-point word. Halves round
// toward +inf; the single positive overflow case saturates to the largest
// integer value. Purely combinational.
module gsim_round_sat
  import gsim_pkg::*;
#(
  parameter int DW   = GSIM_DW,
  parameter int FRAC = GSIM_FRAC
) (
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam logic [DW-1:0] HALF    = DW'(1) << (FRAC - 1);
  localparam logic [DW-1:0] MAX_INT = {1'b0, {(DW - 1 - FRAC){1'b1}}, {FRAC{1'b0}}};

  logic [DW-1:0] sum;
  logic          overflow;

  // Add one half LSB of the integer part, then truncate the fraction.
  // Only a non-negative input can overflow (sign flips from 0 to 1).
  always_comb begin
    sum      = din + HALF;
    overflow = ~din[DW-1] & sum[DW-1];
    if (overflow) begin
      dout = MAX_INT;
    end else begin
      dout = {sum[DW-1:FRAC], {FRAC{1'b0}}};
    end
  end

endmodule : gsim_round_sat

// File: rtl/gsim_result_buffer.sv
// Result buffer behind the Gauss-Seidel engine: captures one N-word burst,
// then drains it over a valid/ready handshake tagged with the word index.
// Optional macro GSIM_RESULT_ROUND_EN rounds drained words to the nearest
// integer (see gsim_round_sat); otherwise words pass through unmodified.
module gsim_result_buffer
  import gsim_pkg::*;
#(
  parameter int N  = GSIM_N,
  parameter int DW = GSIM_DW,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_valid,
  input  logic [DW-1:0] x_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [IW-1:0] m_index,
  output logic          m_last,
  output logic          busy,
  output logic          err_short,
  output logic          err_overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  gsim_rb_state_t state_reg, state_next;
  logic [IW-1:0]  wr_cnt_reg, wr_cnt_next;
  logic [IW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic           err_short_reg, err_short_next;
  logic           err_overrun_reg, err_overrun_next;

  logic           wr_en;
  logic [IW-1:0]  wr_addr;
  logic [DW-1:0]  buf_mem [N];
  logic [DW-1:0]  rd_word;
  logic [DW-1:0]  out_word;
  logic           final_hs;

  // The last handshake of a drain frees slot 0 early, so a new burst may
  // start on exactly that cycle without being counted as an overrun.
  assign final_hs = (state_reg == DRAIN) && m_ready && (rd_ptr_reg == LAST_IDX);

  // Next-state and datapath control for the capture/drain sequence.
  always_comb begin
    state_next       = state_reg;
    wr_cnt_next      = wr_cnt_reg;
    rd_ptr_next      = rd_ptr_reg;
    err_short_next   = err_short_reg;
    err_overrun_next = err_overrun_reg;
    wr_en            = 1'b0;
    wr_addr          = wr_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (x_valid) begin
          wr_en       = 1'b1;
          wr_addr     = '0;
          wr_cnt_next = IW'(1);
          state_next  = CAPTURE;
        end
      end

      CAPTURE: begin
        if (x_valid) begin
          wr_en       = 1'b1;
          wr_addr     = wr_cnt_reg;
          wr_cnt_next = wr_cnt_reg + IW'(1);
          if (wr_cnt_reg == LAST_IDX) begin
            // Full burst captured; the counter wraps to 0 here by design.
            wr_cnt_next = '0;
            rd_ptr_next = '0;
            state_next  = DRAIN;
          end
        end else begin
          // Engine dropped out_valid early: discard the partial burst.
          err_short_next = 1'b1;
          wr_cnt_next    = '0;
          state_next     = IDLE;
        end
      end

      DRAIN: begin
        if (m_ready) begin
          rd_ptr_next = rd_ptr_reg + IW'(1);
        end
        if (final_hs) begin
          rd_ptr_next = '0;
          if (x_valid) begin
            wr_en       = 1'b1;
            wr_addr     = '0;
            wr_cnt_next = IW'(1);
            state_next  = CAPTURE;
          end else begin
            state_next  = IDLE;
          end
        end else if (x_valid) begin
          // Buffer still owned by the drain: the sample is lost.
          err_overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, pointers and sticky error flags; reset abandons any burst.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      wr_cnt_reg      <= '0;
      rd_ptr_reg      <= '0;
      err_short_reg   <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_cnt_reg      <= wr_cnt_next;
      rd_ptr_reg      <= rd_ptr_next;
      err_short_reg   <= err_short_next;
      err_overrun_reg <= err_overrun_next;
    end
  end

  // Burst storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      buf_mem[wr_addr] <= x_in;
    end
  end

  assign rd_word = buf_mem[rd_ptr_reg];

`ifdef GSIM_RESULT_ROUND_EN
  gsim_round_sat #(
    .DW   (DW),
    .FRAC (GSIM_FRAC)
  ) u_round_sat (
    .din  (rd_word),
    .dout (out_word)
  );
`else
  assign out_word = rd_word;
`endif

  // Outputs derive only from registered state; data/index are zeroed
  // outside DRAIN so an idle or freshly reset port shows all zeros.
  always_comb begin
    m_valid     = (state_reg == DRAIN);
    m_data      = m_valid ? out_word : '0;
    m_index     = m_valid ? rd_ptr_reg : '0;
    m_last      = m_valid && (rd_ptr_reg == LAST_IDX);
    busy        = (state_reg != IDLE);
    err_short   = err_short_reg;
    err_overrun = err_overrun_reg;
  end

endmodule : gsim_result_buffer
